// File: rtl/muldiv_seq.sv
// Iterative RV M-extension multiply/divide unit with valid/ready on both sides.
// Latency: XLEN/MUL_STEP+1 (mul), XLEN+1 (div), 1 (div-by-zero / overflow); result held until i_ready.
module muldiv_seq #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            i_clk_n,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_in_a,
    input  logic [XLEN-1:0] i_in_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] CNT_MUL = CW'(XLEN / MUL_STEP);
    localparam logic [CW-1:0] CNT_DIV = CW'(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [2:0]        funct_q;
    logic              neg_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] a_sh;
    logic [XLEN-1:0]   b_q;

    // Accept-side decode
    logic            accept, in_div, sgn_a, sgn_b, neg_a, neg_b, res_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b, special_res;

    assign o_ready = (state == S_IDLE) | ((state == S_DONE) & i_ready);
    assign accept  = i_valid & o_ready & ~i_flush;
    assign o_busy  = (state != S_IDLE);

    assign in_div   = i_funct3[2];
    assign sgn_a    = (i_funct3 == 3'b001) | (i_funct3 == 3'b010) | (in_div & ~i_funct3[0]);
    assign sgn_b    = (i_funct3 == 3'b001) | (in_div & ~i_funct3[0]);
    assign neg_a    = sgn_a & i_in_a[XLEN-1];
    assign neg_b    = sgn_b & i_in_b[XLEN-1];
    assign abs_a    = neg_a ? -i_in_a : i_in_a;
    assign abs_b    = neg_b ? -i_in_b : i_in_b;
    assign res_neg  = (in_div & i_funct3[1]) ? neg_a : (neg_a ^ neg_b);
    assign div_zero = in_div & (i_in_b == '0);
    assign div_ovf  = in_div & ~i_funct3[0] & (i_in_a == {1'b1, {(XLEN-1){1'b0}}}) & (i_in_b == '1);
    assign special_res = div_zero ? (i_funct3[1] ? i_in_a : '1)
                                  : (i_funct3[1] ? '0 : i_in_a);

    // One iteration is retired on the accept edge itself, so the step logic
    // reads either freshly decoded operands or the working registers.
    logic              in_calc, mode_div;
    logic [2*XLEN-1:0] cur_acc, cur_a, mul_acc, div_acc, step_acc;
    logic [XLEN-1:0]   cur_b;
    logic [XLEN:0]     cand;

    assign in_calc  = (state == S_CALC);
    assign mode_div = in_calc ? funct_q[2] : in_div;
    assign cur_a    = in_calc ? a_sh : {{XLEN{1'b0}}, abs_a};
    assign cur_b    = in_calc ? b_q : abs_b;
    assign cur_acc  = in_calc ? acc : (in_div ? {{XLEN{1'b0}}, abs_a} : '0);

    assign mul_acc  = cur_acc + cur_a * {{(2*XLEN-MUL_STEP){1'b0}}, cur_b[MUL_STEP-1:0]};
    assign cand     = cur_acc[2*XLEN-1:XLEN-1] - {1'b0, cur_b};
    assign div_acc  = cand[XLEN] ? {cur_acc[2*XLEN-2:0], 1'b0}
                                 : {cand[XLEN-1:0], cur_acc[XLEN-2:0], 1'b1};
    assign step_acc = mode_div ? div_acc : mul_acc;

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   div_sel, div_res, fix_res;

    assign mul_full = neg_q ? -acc : acc;
    assign div_sel  = funct_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    assign div_res  = neg_q ? -div_sel : div_sel;
    assign fix_res  = funct_q[2] ? div_res
                    : ((funct_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN]);

    always_ff @(posedge i_clk_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            o_valid  <= 1'b0;
            o_result <= '0;
            cnt      <= '0;
            funct_q  <= '0;
            neg_q    <= 1'b0;
            acc      <= '0;
            a_sh     <= '0;
            b_q      <= '0;
        end else if (i_flush) begin
            state   <= S_IDLE;
            o_valid <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        funct_q <= i_funct3;
                        neg_q   <= res_neg;
                        if (div_zero | div_ovf) begin
                            state    <= S_DONE;
                            o_valid  <= 1'b1;
                            o_result <= special_res;
                        end else begin
                            state   <= S_CALC;
                            o_valid <= 1'b0;
                            cnt     <= in_div ? CNT_DIV : CNT_MUL;
                            acc     <= step_acc;
                            a_sh    <= cur_a << MUL_STEP;
                            b_q     <= in_div ? cur_b : (cur_b >> MUL_STEP);
                        end
                    end else if (state == S_DONE && i_ready) begin
                        state   <= S_IDLE;
                        o_valid <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc <= step_acc;
                    cnt <= cnt - CW'(1);
                    if (!funct_q[2]) begin
                        a_sh <= a_sh << MUL_STEP;
                        b_q  <= b_q >> MUL_STEP;
                    end
                    if (cnt == CW'(2)) state <= S_FIX;
                end
                default: begin
                    o_result <= fix_res;
                    o_valid  <= 1'b1;
                    state    <= S_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized checks of muldiv_seq (XLEN=32, MUL_STEP=4) against an arithmetic reference.
module tb_muldiv_seq;

    localparam int MS      = 4;
    localparam int MUL_LAT = 32 / MS + 1;
    localparam int DIV_LAT = 33;

    logic        i_clk_n, i_rst_n, i_valid, o_ready, i_flush, o_valid, i_ready, o_busy;
    logic [2:0]  i_funct3;
    logic [31:0] i_in_a, i_in_b, o_result;

    int total = 0;
    int bad   = 0;

    muldiv_seq #(.XLEN(32), .MUL_STEP(MS)) dut (
        .i_clk_n (i_clk_n),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_funct3(i_funct3),
        .i_in_a  (i_in_a),
        .i_in_b  (i_in_b),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_result(o_result),
        .o_busy  (o_busy)
    );

    initial i_clk_n = 1'b0;
    always #5 i_clk_n = ~i_clk_n;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DIV_LAT;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!o_valid && cyc < 200) begin
            @(posedge i_clk_n); #1;
            cyc++;
        end
    endtask

    // Issue one op from IDLE, check latency and result; completes the handshake if i_ready is high.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_lat, input string tag);
        int cyc;
        chk(32'(o_ready), 32'd1, {tag, "_rdy"});
        i_funct3 = f; i_in_a = a; i_in_b = b; i_valid = 1'b1;
        @(posedge i_clk_n); #1;
        i_valid  = 1'b0;
        i_funct3 = 3'($urandom);
        i_in_a   = $urandom;
        i_in_b   = $urandom;
        wait_valid(cyc);
        chk(32'(cyc), 32'(exp_lat), {tag, "_lat"});
        chk(o_result, exp_r, tag);
        if (i_ready) begin
            @(posedge i_clk_n); #1;
            chk(32'(o_valid), 32'd0, {tag, "_vld_drop"});
            chk(o_result, exp_r, {tag, "_keep"});
        end
    endtask

    logic [2:0]  d_f   [12] = '{3'd3, 3'd1, 3'd0, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] d_a   [12] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'd100, 32'd100, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
    logic [31:0] d_b   [12] = '{32'hFFFFFFFF, 32'd3, 32'd3, 32'd2, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] d_exp [12] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                32'd14, 32'd2, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd5};
    int          d_lat [12] = '{MUL_LAT, MUL_LAT, MUL_LAT, MUL_LAT, DIV_LAT, DIV_LAT,
                                DIV_LAT, DIV_LAT, 1, 1, 1, 1};

    initial begin
        int cyc;
        logic seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_funct3 = '0; i_in_a = '0; i_in_b = '0;

        // Reset state
        repeat (3) @(posedge i_clk_n);
        #1;
        chk(32'(o_valid), 32'd0, "rst_vld");
        chk(o_result, 32'd0, "rst_res");
        chk(32'(o_busy), 32'd0, "rst_busy");
        i_rst_n = 1'b1;
        @(posedge i_clk_n); #1;
        chk(32'(o_ready), 32'd1, "rst_rdy");

        // Directed vectors including special cases
        for (int i = 0; i < 12; i++)
            run_op(d_f[i], d_a[i], d_b[i], d_exp[i], d_lat[i], $sformatf("dir%0d", i));

        // Random operations against the reference
        for (int i = 0; i < 60; i++) begin
            rf = 3'($urandom);
            ra = pick();
            rb = pick();
            run_op(rf, ra, rb, model(rf, ra, rb), model_lat(rf, ra, rb), $sformatf("rnd%0d_f%0d", i, rf));
        end

        // Back-pressure hold, then back-to-back accept from DONE
        i_ready = 1'b0;
        run_op(3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT, "hold");
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk_n); #1;
            chk(32'(o_valid), 32'd1, $sformatf("hold_vld%0d", i));
            chk(o_result, 32'd14, $sformatf("hold_res%0d", i));
        end
        chk(32'(o_ready), 32'd0, "hold_rdy");
        i_funct3 = 3'd0; i_in_a = 32'hFFFFFFF9; i_in_b = 32'd3; i_valid = 1'b1; i_ready = 1'b1;
        #1;
        chk(32'(o_ready), 32'd1, "b2b_rdy");
        @(posedge i_clk_n); #1;
        i_valid = 1'b0;
        chk(32'(o_busy), 32'd1, "b2b_busy");
        chk(32'(o_valid), 32'd0, "b2b_vld");
        wait_valid(cyc);
        chk(32'(cyc), 32'(MUL_LAT), "b2b_lat");
        chk(o_result, 32'hFFFFFFEB, "b2b_res");
        @(posedge i_clk_n); #1;

        // Flush in CALC cycle 5 aborts; a simultaneous request is ignored
        i_funct3 = 3'd4; i_in_a = 32'd1000; i_in_b = 32'd7; i_valid = 1'b1;
        @(posedge i_clk_n); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk_n);
        #1;
        i_flush = 1'b1; i_valid = 1'b1; i_funct3 = 3'd5; i_in_a = 32'd9; i_in_b = 32'd3;
        @(posedge i_clk_n); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        chk(32'(o_busy), 32'd0, "flush_busy");
        chk(32'(o_valid), 32'd0, "flush_vld");
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk_n); #1;
            if (o_valid) seen = 1'b1;
        end
        chk(32'(seen), 32'd0, "flush_no_vld");
        run_op(3'd5, 32'd9, 32'd3, 32'd3, DIV_LAT, "flush_next");

        // Reset in the middle of an operation
        i_funct3 = 3'd0; i_in_a = 32'd7; i_in_b = 32'd3; i_valid = 1'b1;
        @(posedge i_clk_n); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk_n);
        #1;
        i_rst_n = 1'b0;
        @(posedge i_clk_n); #1;
        chk(32'(o_valid), 32'd0, "midrst_vld");
        chk(o_result, 32'd0, "midrst_res");
        chk(32'(o_busy), 32'd0, "midrst_busy");
        i_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk_n); #1;
            if (o_valid) seen = 1'b1;
        end
        chk(32'(seen), 32'd0, "midrst_no_vld");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
